ds_sample_capture: RTL and testbench



---
 rtl/ds_sample_capture.sv | 124 ++++++++++++
 tb/tb_ds_sample_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ds_sample_capture.sv
// rtl/ds_sample_capture.sv - decimation clock generator, settle-discarding sample capture and show-ahead FIFO
module ds_sample_capture #(
   parameter int DEC_RATIO  = 64,
   parameter int DATA_W     = 20,
   parameter int FIFO_DEPTH = 8,
   parameter int SETTLE     = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   output logic                          dclk,
   input  logic [DATA_W-1:0]             din,
   output logic                          m_valid,
   output logic [DATA_W-1:0]             m_data,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          ovf,
   input  logic                          clr_ovf
);

   localparam int CNT_W = $clog2(DEC_RATIO);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_RATIO - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEC_RATIO / 2);
   localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [SET_W-1:0]  settle_cnt;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              strobe;
   logic              settled;
   logic              push_req;
   logic              pop;
   logic              full;
   logic              push_ok;
   logic              ovf_set;

   // Strobe on the last count of a period so din has had the longest settling since the dclk rise
   always_comb begin
      strobe   = en && (cnt == CNT_LAST);
      cnt_nxt  = '0;
      if (en && !strobe) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
      settled  = (settle_cnt >= SET_MAX);
      push_req = strobe && settled;
      pop      = m_valid && m_ready;
      full     = (level == LVL_FULL);
      push_ok  = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop;
   end

   // Divider: dclk is registered from the next count so it rises as the count returns to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         dclk <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         dclk <= en && (cnt_nxt < CNT_HALF);
      end
   end

   // Count discarded captures until the sinc3 chain has settled; restart whenever disabled
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         settle_cnt <= '0;
      end else if (strobe && !settled) begin
         settle_cnt <= settle_cnt + SET_W'(1);
      end
   end

   // Sample storage; needs no reset because m_data is masked while empty
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged even when full
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_ok && !pop) begin
            level <= level + (PTR_W + 1)'(1);
         end else if (pop && !push_ok) begin
            level <= level - (PTR_W + 1)'(1);
         end
      end
   end

   // Sticky overflow; a new overflow wins over a clear in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (ovf_set) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

   // Show-ahead head of the FIFO
   always_comb begin
      m_valid = (level != '0);
      m_data  = m_valid ? mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_ds_sample_capture.sv
// tb/tb_ds_sample_capture.sv - randomized self-checking bench for ds_sample_capture against a queue model
module tb_ds_sample_capture;

   localparam int DR = 8;
   localparam int DW = 20;
   localparam int FD = 8;
   localparam int ST = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          dclk;
   logic [DW-1:0] din;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [3:0]    level;
   logic          ovf;
   logic          clr_ovf;

   int errors = 0;
   int checks = 0;

   // reference model state: enabled-cycle count, settle discards, sample queue
   int            run;
   int            settle;
   logic [DW-1:0] q[$];
   logic          exp_ovf;
   logic          exp_dclk;

   ds_sample_capture #(
      .DEC_RATIO (DR),
      .DATA_W    (DW),
      .FIFO_DEPTH(FD),
      .SETTLE    (ST)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .dclk   (dclk),
      .din    (din),
      .m_valid(m_valid),
      .m_data (m_data),
      .m_ready(m_ready),
      .level  (level),
      .ovf    (ovf),
      .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock: update the model from the current inputs, then compare all outputs
   task automatic step();
      bit          strobe;
      bit          popped;
      bit          pushing;
      bit          lost;
      logic [DW-1:0] head;
      if (rst) begin
         run      = 0;
         settle   = 0;
         q.delete();
         exp_ovf  = 1'b0;
         exp_dclk = 1'b0;
      end else begin
         popped  = (q.size() > 0) && m_ready;
         strobe  = en && ((run % DR) == DR - 1);
         pushing = 1'b0;
         if (strobe) begin
            if (settle < ST) settle++;
            else pushing = 1'b1;
         end
         lost = pushing && !popped && (q.size() == FD);
         if (popped) void'(q.pop_front());
         if (pushing && !lost) q.push_back(din);
         if (lost) exp_ovf = 1'b1;
         else if (clr_ovf) exp_ovf = 1'b0;
         if (en) run++;
         else begin
            run    = 0;
            settle = 0;
         end
         exp_dclk = en && ((run % DR) < DR / 2);
      end
      @(posedge clk);
      @(negedge clk);
      head = (q.size() > 0) ? q[0] : '0;
      check("dclk",    32'(dclk),    32'(exp_dclk));
      check("m_valid", 32'(m_valid), 32'(q.size() > 0));
      check("level",   32'(level),   32'(q.size()));
      check("m_data",  32'(m_data),  32'(head));
      check("ovf",     32'(ovf),     32'(exp_ovf));
   endtask

   initial begin
      bit found;
      rst = 1'b1; en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0; din = '0;
      @(negedge clk);
      step();
      step();
      check("reset_level", 32'(level), 32'd0);
      check("reset_dclk",  32'(dclk),  32'd0);
      rst = 1'b0;

      // start-up: din carries the cycle index, first kept sample is cycle 31
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         din = DW'(i);
         step();
         if (i == 30) check("no_valid_before_31", 32'(m_valid), 32'd0);
         if (i == 31) begin
            check("first_valid",  32'(m_valid), 32'd1);
            check("first_sample", 32'(m_data),  32'd31);
         end
      end

      // stall for 12 periods: fill to 8, then overflow
      m_ready = 1'b0;
      for (int i = 0; i < 12 * DR; i++) begin
         din = DW'($urandom);
         step();
      end
      check("stall_level", 32'(level), 32'd8);
      check("stall_ovf",   32'(ovf),   32'd1);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = DW'($urandom);
         step();
      end

      // full FIFO, pop exactly on strobe cycles: no growth, no overflow
      clr_ovf = 1'b1; m_ready = 1'b0;
      step();
      clr_ovf = 1'b0;
      for (int i = 0; i < 100 && q.size() < FD; i++) begin
         din = DW'($urandom);
         step();
      end
      check("fill_reached", 32'(q.size() == FD), 32'd1);
      for (int i = 0; i < 3 * DR; i++) begin
         m_ready = ((run % DR) == DR - 1);
         din = DW'($urandom);
         step();
      end
      check("strobe_pop_level", 32'(level), 32'd8);
      check("strobe_pop_ovf",   32'(ovf),   32'd0);

      // overflow set coincides with clear: set wins, then clear alone drops it
      m_ready = 1'b0; clr_ovf = 1'b1;
      for (int i = 0; i < DR && (run % DR) != DR - 1; i++) step();
      din = DW'($urandom);
      step();
      check("ovf_set_beats_clr", 32'(ovf), 32'd1);
      step();
      check("ovf_cleared", 32'(ovf), 32'd0);
      clr_ovf = 1'b0;

      // drain some, then drop en at cnt=4 and re-enable with the contents held
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         din = DW'($urandom);
         step();
      end
      m_ready = 1'b0;
      for (int i = 0; i < DR && (run % DR) != 4; i++) step();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = DW'($urandom);
         step();
         check("en_low_dclk", 32'(dclk), 32'd0);
      end
      en = 1'b1;
      for (int i = 0; i < 5 * DR; i++) begin
         din = DW'($urandom);
         step();
      end

      // reset while holding 5 samples with dclk high
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 5 && exp_dclk) begin
            found = 1'b1;
            break;
         end
         m_ready = (q.size() > 5);
         din = DW'($urandom);
         step();
      end
      check("rst_setup_reached", 32'(found), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_level",   32'(level),   32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_dclk",    32'(dclk),    32'd0);
      check("rst_ovf",     32'(ovf),     32'd0);

      // randomized soak
      for (int i = 0; i < 1500; i++) begin
         rst     = ($urandom_range(199) == 0);
         en      = ($urandom_range(29) != 0);
         m_ready = ($urandom_range(2) != 0);
         clr_ovf = ($urandom_range(19) == 0);
         din     = DW'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
